// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out converter. Accepts WIDTH-bit words over a
//   valid/ready handshake and shifts them out one bit per enabled clock.
//   A one-word holding buffer lets back-to-back words stream with no gap bit.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   data_in     parallel word to serialise
//   load_valid  data_in valid this cycle
//   load_ready  block can accept a word (registered)
//   shift_en    1 = advance the serial stream, 0 = hold current bit
//   data_out    current serial bit
//   out_valid   data_out carries a valid bit
//   last        data_out is the final bit of the current word
//   busy        shifter active or holding buffer full
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             data_out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_t;

    state_t           r_state, w_state_d;
    logic [WIDTH-1:0] r_sreg, w_sreg_d;
    logic [CW-1:0]    r_cnt, w_cnt_d;
    logic [WIDTH-1:0] r_hold, w_hold_d;
    logic             r_hold_full, w_hold_full_d;
    logic             r_load_ready, w_load_ready_d;

    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;

    assign w_accept  = load_valid && r_load_ready;
    // Shift toward the output end; the vacated bit fills with zero.
    assign w_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};

    always_comb begin
        w_state_d     = r_state;
        w_sreg_d      = r_sreg;
        w_cnt_d       = r_cnt;
        w_hold_d      = r_hold;
        w_hold_full_d = r_hold_full;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_sreg_d  = data_in;
                    w_cnt_d   = CNT_MAX;
                    w_state_d = StShift;
                end
            end
            StShift: begin
                // Default: an accept while shifting parks the word in the buffer.
                if (w_accept) begin
                    w_hold_d      = data_in;
                    w_hold_full_d = 1'b1;
                end
                if (shift_en) begin
                    if (r_cnt != '0) begin
                        w_sreg_d = w_shifted;
                        w_cnt_d  = r_cnt - CW'(1);
                    end else if (r_hold_full) begin
                        // load_ready is low here, so no accept can collide.
                        w_sreg_d      = r_hold;
                        w_cnt_d       = CNT_MAX;
                        w_hold_full_d = 1'b0;
                    end else if (w_accept) begin
                        // Same-edge accept on the final bit bypasses the buffer.
                        w_sreg_d      = data_in;
                        w_cnt_d       = CNT_MAX;
                        w_hold_full_d = 1'b0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_load_ready_d = !w_hold_full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_load_ready <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_sreg       <= w_sreg_d;
            r_cnt        <= w_cnt_d;
            r_hold       <= w_hold_d;
            r_hold_full  <= w_hold_full_d;
            r_load_ready <= w_load_ready_d;
        end
    end

    // Outputs decode from registers only, so reset clears them without a clock.
    always_comb begin
        out_valid  = (r_state == StShift);
        data_out   = out_valid && (MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0]);
        last       = out_valid && (r_cnt == '0);
        busy       = out_valid || r_hold_full;
        load_ready = r_load_ready;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed self-checking bench. Three instances share clock, reset, data and
//   shift_en: 8-bit MSB-first (0), 8-bit LSB-first (1), 12-bit MSB-first (2).
//   Each instance has its own load_valid so only one is loaded at a time.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        shift_en;
    logic        lv   [3];
    logic        lr   [3];
    logic        dout [3];
    logic        ovld [3];
    logic        lst  [3];
    logic        bsy  [3];

    int n_checks;
    int n_fail;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (din[7:0]),
        .load_valid (lv[0]),
        .load_ready (lr[0]),
        .shift_en   (shift_en),
        .data_out   (dout[0]),
        .out_valid  (ovld[0]),
        .last       (lst[0]),
        .busy       (bsy[0])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (din[7:0]),
        .load_valid (lv[1]),
        .load_ready (lr[1]),
        .shift_en   (shift_en),
        .data_out   (dout[1]),
        .out_valid  (ovld[1]),
        .last       (lst[1]),
        .busy       (bsy[1])
    );

    piso_serializer #(.WIDTH(12), .MSB_FIRST(1'b1)) u_dut_w12 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (din[11:0]),
        .load_valid (lv[2]),
        .load_ready (lr[2]),
        .shift_en   (shift_en),
        .data_out   (dout[2]),
        .out_valid  (ovld[2]),
        .last       (lst[2]),
        .busy       (bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return 1 ns after the edge so outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load one word into instance sel and check every serial bit it emits.
    task automatic send_word(input int sel, input logic [31:0] word, input int width,
                             input bit msb);
        logic exp_bit;
        for (int k = 0; k < 20 && !lr[sel]; k++) step();
        check("ready_before_load", 32'(lr[sel]), 32'd1);
        din     = word;
        lv[sel] = 1'b1;
        step();
        lv[sel] = 1'b0;
        for (int i = 0; i < width; i++) begin
            exp_bit = msb ? word[width-1-i] : word[i];
            check($sformatf("w%0d_bit%0d", sel, i), 32'(dout[sel]), 32'(exp_bit));
            check($sformatf("w%0d_vld%0d", sel, i), 32'(ovld[sel]), 32'd1);
            check($sformatf("w%0d_last%0d", sel, i), 32'(lst[sel]), 32'(i == width - 1));
            step();
        end
        check($sformatf("w%0d_idle_vld", sel), 32'(ovld[sel]), 32'd0);
        check($sformatf("w%0d_idle_busy", sel), 32'(bsy[sel]), 32'd0);
        check($sformatf("w%0d_idle_dout", sel), 32'(dout[sel]), 32'd0);
    endtask

    initial begin
        logic [15:0] stream;
        int          idx;
        int          stall_cnt;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        din      = '0;
        shift_en = 1'b1;
        for (int s = 0; s < 3; s++) lv[s] = 1'b0;

        // Reset state
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_ready%0d", s), 32'(lr[s]), 32'd0);
            check($sformatf("rst_vld%0d", s), 32'(ovld[s]), 32'd0);
            check($sformatf("rst_busy%0d", s), 32'(bsy[s]), 32'd0);
        end
        rst = 1'b1;
        #1;
        check("ready_before_edge", 32'(lr[0]), 32'd0);
        step();
        check("ready_after_release", 32'(lr[0]), 32'd1);

        // 1. Single word, MSB first
        send_word(0, 32'hCA, 8, 1'b1);

        // 2. LSB first
        send_word(1, 32'h56, 8, 1'b0);

        // 3. Back-to-back words with no gap
        stream = 16'hCA56;
        din    = 32'hCA;
        lv[0]  = 1'b1;
        step();
        lv[0]  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b_bit%0d", i), 32'(dout[0]), 32'(stream[15-i]));
            check($sformatf("b2b_vld%0d", i), 32'(ovld[0]), 32'd1);
            check($sformatf("b2b_last%0d", i), 32'(lst[0]), 32'(i == 7 || i == 15));
            if (i == 1) begin
                din   = 32'h56;
                lv[0] = 1'b1;
            end
            if (i == 2) begin
                lv[0] = 1'b0;
                check("b2b_ready_low", 32'(lr[0]), 32'd0);
                check("b2b_busy", 32'(bsy[0]), 32'd1);
            end
            if (i == 7) check("b2b_ready_pre_xfer", 32'(lr[0]), 32'd0);
            if (i == 8) check("b2b_ready_post_xfer", 32'(lr[0]), 32'd1);
            step();
        end
        check("b2b_end_vld", 32'(ovld[0]), 32'd0);

        // 4. Stall for 3 cycles on bit index 3 while buffering a second word
        stream    = 16'hCA3C;
        stall_cnt = 0;
        idx       = 0;
        din       = 32'hCA;
        lv[0]     = 1'b1;
        step();
        lv[0]     = 1'b0;
        for (int c = 0; c < 19; c++) begin
            check($sformatf("stall_bit_c%0d", c), 32'(dout[0]), 32'(stream[15-idx]));
            check($sformatf("stall_vld_c%0d", c), 32'(ovld[0]), 32'd1);
            check($sformatf("stall_last_c%0d", c), 32'(lst[0]), 32'(idx == 7 || idx == 15));
            lv[0] = 1'b0;
            if (c == 4) check("stall_buffered", 32'(lr[0]), 32'd0);
            if (idx == 3 && stall_cnt < 3) begin
                if (stall_cnt == 0) begin
                    din   = 32'h3C;
                    lv[0] = 1'b1;
                end
                shift_en = 1'b0;
                stall_cnt++;
            end else begin
                shift_en = 1'b1;
                idx++;
            end
            step();
        end
        lv[0]    = 1'b0;
        shift_en = 1'b1;
        check("stall_end_vld", 32'(ovld[0]), 32'd0);

        // 5. Asynchronous reset mid-word with a word buffered
        din   = 32'h37;
        lv[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        step();
        din   = 32'hC3;
        lv[0] = 1'b1;
        step();
        lv[0] = 1'b0;
        step();
        step();
        step();
        check("mid_bit5", 32'(dout[0]), 32'd1);
        check("mid_busy", 32'(bsy[0]), 32'd1);
        check("mid_ready", 32'(lr[0]), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("arst_dout", 32'(dout[0]), 32'd0);
        check("arst_vld", 32'(ovld[0]), 32'd0);
        check("arst_last", 32'(lst[0]), 32'd0);
        check("arst_busy", 32'(bsy[0]), 32'd0);
        check("arst_ready", 32'(lr[0]), 32'd0);
        #3 rst = 1'b1;
        step();
        send_word(0, 32'hFF, 8, 1'b1);

        // 6. 12-bit instance
        send_word(2, 32'hA5C, 12, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out converter, successor to the fixed 8-bit serialisers.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled clock.
- One-word holding buffer so back-to-back words stream with no idle bit between them.
- Sits between a parallel data source and a 1-bit serial link; shift order is selectable, and the output can be stalled.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  parallel word to serialise.
load_valid  input  1  data_in is valid this cycle.
load_ready  output  1  block can accept a word this cycle.
shift_en  input  1  1 = advance the serial stream this cycle; 0 = hold the current bit.
data_out  output  1  current serial bit.
out_valid  output  1  data_out carries a valid bit.
last  output  1  data_out is the final bit of the current word.
busy  output  1  shifter active or holding buffer full.

Behaviour:
- Reset:
  - Single clock domain clk; reset is asynchronous, active-low, on rst.
  - While rst=0: state=IDLE, shift register=0, bit counter=0, holding buffer empty, data_out=0, out_valid=0, last=0, busy=0, load_ready=0.
  - load_ready goes 1 on the first clk edge after rst releases.
  - Reset asserted mid-word aborts the word immediately; remaining bits and any buffered word are discarded and not resent.
- Handshake:
  - Accept occurs on a rising edge with load_valid=1 and load_ready=1.
  - load_ready = !hold_full; it is a registered flag, with no combinational path from load_valid.
  - load_valid with load_ready=0 is ignored; the source must hold data_in stable.
- State IDLE (out_valid=0, data_out=0):
  - On accept, the word goes directly into the shift register and the counter loads WIDTH-1; next state SHIFT.
  - First bit appears on data_out in the cycle after the accept edge: one-cycle latency.
- State SHIFT (out_valid=1):
  - data_out = sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
  - On an edge with shift_en=1 and counter>0: shift by one toward the output end, decrement the counter.
  - On an edge with shift_en=1 and counter=0 (last=1 this cycle):
    - If the holding buffer is full, or an accept occurs this same edge, load that word and set counter=WIDTH-1; stay in SHIFT with no gap bit.
    - Otherwise go to IDLE.
  - shift_en=0: data_out, counter and last hold. Accepts into the holding buffer are still allowed.
- Holding buffer:
  - An accept while in SHIFT writes the holding buffer and sets hold_full.
  - Same-edge accept and final-bit shift pass the word straight through to the shift register; hold_full stays 0.
  - hold_full clears when its word transfers to the shift register.
  - At most one word is buffered; load_ready=0 while hold_full=1.
- Output flags:
  - last = out_valid && (counter==0).
  - busy = (state==SHIFT) || hold_full.
- Each word occupies exactly WIDTH enabled cycles on data_out. Bits are never duplicated or dropped except on reset.

Test Plan:
1. Reset then single word (WIDTH=8, MSB_FIRST=1), data_in=8'b11001010 accepted at edge N, shift_en=1 -> data_out = 1,1,0,0,1,0,1,0 in cycles N+1..N+8. last=1 only in cycle N+8; out_valid=0 and busy=0 from N+9.
2. MSB_FIRST=0, data_in=8'b01010110 -> data_out = 0,1,1,0,1,0,1,0 with last on the 8th bit.
3. Back-to-back: 8'hCA accepted, then 8'h56 accepted two cycles later -> load_ready=0 after the second accept. 16 contiguous valid bits with no gap; last pulses at bits 8 and 16; load_ready returns to 1 at the transfer edge.
4. Stall: shift_en=0 for 3 cycles after bit 3 of 8'hCA -> data_out holds bit 3 for 4 cycles total, then the remaining bits follow in order; a load attempted during the stall is buffered.
5. Reset mid-word: rst=0 asynchronously during bit 5 with a word buffered -> all outputs 0 immediately with no clock needed. After release, a fresh 8'hFF serialises cleanly with no stale bits.
6. WIDTH=12 build: 12'hA5C -> 12 bits MSB-first (1010_0101_1100), last on bit 12, same one-cycle latency.
